// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Width of the iteration counter for a WIDTH-bit multiplier.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for seq_mult: sequences WIDTH RUN cycles plus one FINISH cycle,
// and generates accept, busy and the registered done strobe.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  output logic   accept,
  output logic   busy,
  output logic   done,
  output state_t state
);

  localparam int CW = cnt_w(WIDTH);

  state_t        state_next;
  logic [CW-1:0] count;
  logic          last_bit;

  assign last_bit = (count == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    accept     = start && (state == IDLE || state == FINISH);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bit) state_next = FINISH;
      FINISH:  state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered so it rises together with the product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FINISH);
      if (accept)
        count <= '0;
      else if (state == RUN)
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  logic               accept;
  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] result;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .accept (accept),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

`ifdef SEQ_MULT_SIGNED_EN
  logic sign;

  // Negating the most-negative value wraps to itself, which read as
  // unsigned is exactly its magnitude.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign result = sign ? -acc : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sign <= 1'b0;
    else if (accept)
      sign <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      p      <= '0;
    end else begin
      // In a back-to-back FINISH, p captures the old acc before it is cleared.
      if (state == FINISH)
        p <= result;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
      end else if (state == RUN) begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule
